// File: rtl/mem_lsu_pkg.sv
// Shared constants, state encoding and store/legality helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsu_state_e;

  // Unsigned widths exist only for loads; every access must be naturally aligned.
  function automatic logic access_legal(input logic is_load, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~addr_lo[0];
      F3_LW:   ok = (addr_lo == 2'b00);
      F3_LBU:  ok = is_load;
      F3_LHU:  ok = is_load & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'b00:   strb = 4'b0001 << addr_lo;
      2'b01:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [REG_BUS-1:0] store_data(input logic [1:0] size,
                                                    input logic [REG_BUS-1:0] data);
    logic [REG_BUS-1:0] rep;
    case (size)
      2'b00:   rep = {4{data[7:0]}};
      2'b01:   rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]         funct3,
  input  logic [1:0]         addr_lo,
  input  logic [REG_BUS-1:0] rdata,
  output logic [REG_BUS-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LHU:  data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one DRAM req/ack transaction per memory op and
// produces the registered writeback result plus a pipeline stall request.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic                    is_load_i,
  input  logic                    is_store_i,
  input  logic [2:0]              funct3_i,
  input  logic [REG_BUS-1:0]      addr_i,
  input  logic [REG_BUS-1:0]      wdata_i,
  input  logic [REG_ADDR_BUS-1:0] rd_addr_i,
  input  logic                    wreg_i,
  output logic [REG_ADDR_BUS-1:0] rd_addr_o,
  output logic                    wreg_o,
  output logic [REG_BUS-1:0]      wdata_o,
  output logic                    valid_o,
  output logic                    fault_o,
  output logic                    bus_err_o,
  output logic                    stall_req_o,
  output logic                    dram_req_o,
  output logic                    dram_we_o,
  output logic [REG_BUS-1:0]      dram_addr_o,
  output logic [3:0]              dram_wstrb_o,
  output logic [REG_BUS-1:0]      dram_wdata_o,
  input  logic                    dram_ack_i,
  input  logic [REG_BUS-1:0]      dram_rdata_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e              state;
  logic [CW-1:0]           cnt;
  logic [2:0]              funct3_q;
  logic [1:0]              addr_lo_q;
  logic [REG_ADDR_BUS-1:0] rd_q;
  logic                    wreg_q;
  logic [REG_BUS-1:0]      load_data;
  logic                    is_mem;
  logic                    legal;

  assign is_mem      = is_load_i | is_store_i;
  assign legal       = access_legal(is_load_i, funct3_i, addr_i[1:0]);
  assign stall_req_o = (state == ST_BUSY);

  lsu_load_align u_align (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .rdata   (dram_rdata_i),
    .data    (load_data)
  );

  // Async reset also drops an in-flight request; the DRAM side tolerates abandonment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      rd_q         <= '0;
      wreg_q       <= 1'b0;
      rd_addr_o    <= '0;
      wreg_o       <= 1'b0;
      wdata_o      <= '0;
      valid_o      <= 1'b0;
      fault_o      <= 1'b0;
      bus_err_o    <= 1'b0;
      dram_req_o   <= 1'b0;
      dram_we_o    <= 1'b0;
      dram_addr_o  <= '0;
      dram_wstrb_o <= '0;
      dram_wdata_o <= '0;
    end else begin
      valid_o   <= 1'b0;
      fault_o   <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o   <= 1'b1;
              rd_addr_o <= rd_addr_i;
              wreg_o    <= wreg_i;
              wdata_o   <= wdata_i;
            end else if (!legal) begin
              valid_o   <= 1'b1;
              fault_o   <= 1'b1;
              wreg_o    <= 1'b0;
              rd_addr_o <= rd_addr_i;
            end else begin
              state        <= ST_BUSY;
              cnt          <= '0;
              dram_req_o   <= 1'b1;
              dram_we_o    <= is_store_i;
              dram_addr_o  <= {addr_i[31:2], 2'b00};
              dram_wstrb_o <= is_store_i ? store_strobe(funct3_i[1:0], addr_i[1:0]) : 4'b0000;
              dram_wdata_o <= is_store_i ? store_data(funct3_i[1:0], wdata_i) : '0;
              funct3_q     <= funct3_i;
              addr_lo_q    <= addr_i[1:0];
              rd_q         <= rd_addr_i;
              wreg_q       <= wreg_i;
            end
          end
        end
        ST_BUSY: begin
          // An ack arriving on the final timeout cycle still completes normally.
          if (dram_ack_i) begin
            state      <= ST_IDLE;
            dram_req_o <= 1'b0;
            valid_o    <= 1'b1;
            rd_addr_o  <= rd_q;
            if (dram_we_o) begin
              wreg_o  <= 1'b0;
              wdata_o <= '0;
            end else begin
              wreg_o  <= wreg_q;
              wdata_o <= load_data;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state      <= ST_IDLE;
            dram_req_o <= 1'b0;
            valid_o    <= 1'b1;
            bus_err_o  <= 1'b1;
            wreg_o     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
